// File: rtl/dac_spi_driver_pkg.sv
// Shared constants for the SPI DAC driver: frame geometry and FSM state encodings.
package dac_pkg;
    localparam int FRAME_BITS   = 16;
    localparam int DAC_BITS_DEF = 12;
    localparam int CTRL_W       = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
endpackage

// File: rtl/dac_spi_driver_if.sv
// Sample stream handshake between the waveform source and the DAC driver.
interface dac_spi_driver_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_spi_driver_sclk_tick_gen.sv
// Half-period tick generator for SCLK: one-cycle tick every CLK_DIV clocks while enabled.
module sclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = en & (cnt_reg == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr || tick) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/dac_spi_driver.sv
// Serialises one 16-bit sample per handshake into a {ctrl, sample MSBs} SPI frame for a 12-bit DAC.
import dac_pkg::*;

module dac_spi_driver #(
    parameter int         CLK_DIV    = 2,
    parameter int         GAP_CYCLES = 2,
    parameter int         DAC_BITS   = DAC_BITS_DEF,
    parameter logic [3:0] CTRL_BITS  = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    dac_spi_driver_if.slave   s,
    output logic              dac_sync_n,
    output logic              dac_sclk,
    output logic              dac_sdo,
    output logic              busy,
    output logic              frame_done
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [1:0]            state_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [3:0]            bit_cnt_reg;
    logic [GW-1:0]         gap_cnt_reg;
    logic                  run_reg;
    logic                  sync_n_reg, sclk_reg, sdo_reg, busy_reg, done_reg;
    logic [FRAME_BITS-1:0] frame_word;
    logic                  accept, tick;

    // run_reg keeps s_ready low until the first edge after reset release
    assign s.s_ready = (state_reg == ST_IDLE) & ena & run_reg;
    assign accept    = s.s_valid & s.s_ready;

    always_comb begin
        frame_word = '0;
        frame_word[FRAME_BITS-1 -: CTRL_W] = CTRL_BITS;
        frame_word[FRAME_BITS-1-CTRL_W -: DAC_BITS] = s.s_data[15 -: DAC_BITS];
    end

    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state_reg == ST_SHIFT),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            run_reg     <= 1'b0;
            sync_n_reg  <= 1'b1;
            sclk_reg    <= 1'b1;
            sdo_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            run_reg  <= 1'b1;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        shift_reg   <= frame_word;
                        sdo_reg     <= frame_word[FRAME_BITS-1];
                        sync_n_reg  <= 1'b0;
                        sclk_reg    <= 1'b1;
                        busy_reg    <= 1'b1;
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (sclk_reg) begin
                            sclk_reg <= 1'b0;
                        end else if (bit_cnt_reg == 4'd15) begin
                            // 16th rising edge closes the frame instead of shifting
                            sclk_reg    <= 1'b1;
                            sync_n_reg  <= 1'b1;
                            sdo_reg     <= 1'b0;
                            done_reg    <= 1'b1;
                            bit_cnt_reg <= '0;
                            gap_cnt_reg <= '0;
                            state_reg   <= ST_GAP;
                        end else begin
                            sclk_reg    <= 1'b1;
                            sdo_reg     <= shift_reg[FRAME_BITS-2];
                            shift_reg   <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GW'(GAP_CYCLES - 1)) begin
                        gap_cnt_reg <= '0;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign dac_sync_n = sync_n_reg;
    assign dac_sclk   = sclk_reg;
    assign dac_sdo    = sdo_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;
endmodule

// File: tb/tb_dac_spi_driver.sv
// Directed bench: default-parameter driver (a) plus a CLK_DIV=1/GAP_CYCLES=1 driver (b).
module tb_dac_spi_driver;
    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dac_spi_driver_if a_if();
    dac_spi_driver_if b_if();
    logic a_sync_n, a_sclk, a_sdo, a_busy, a_done;
    logic b_sync_n, b_sclk, b_sdo, b_busy, b_done;

    dac_spi_driver #(.CLK_DIV(2), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .s(a_if.slave),
        .dac_sync_n(a_sync_n), .dac_sclk(a_sclk), .dac_sdo(a_sdo),
        .busy(a_busy), .frame_done(a_done)
    );

    dac_spi_driver #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .s(b_if.slave),
        .dac_sync_n(b_sync_n), .dac_sclk(b_sclk), .dac_sdo(b_sdo),
        .busy(b_busy), .frame_done(b_done)
    );

    // Stamps: an event seen at a negedge belongs to cycle/edge number cyc+1
    int a_acc_q[$], a_done_q[$], a_word_q[$], a_nbit_q[$];
    int b_acc_q[$], b_done_q[$], b_word_q[$], b_nbit_q[$];
    logic        a_prev = 1'b1, b_prev = 1'b1;
    logic [15:0] a_cap = '0, b_cap = '0;
    int          a_bits = 0, b_bits = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_prev = 1'b1; a_bits = 0;
        end else begin
            if (a_if.s_valid && a_if.s_ready) begin a_acc_q.push_back(cyc + 1); a_bits = 0; a_cap = '0; end
            if (a_prev && !a_sclk && !a_sync_n) begin a_cap = {a_cap[14:0], a_sdo}; a_bits++; end
            if (a_done) begin a_done_q.push_back(cyc + 1); a_word_q.push_back(int'(a_cap)); a_nbit_q.push_back(a_bits); end
            a_prev = a_sclk;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_prev = 1'b1; b_bits = 0;
        end else begin
            if (b_if.s_valid && b_if.s_ready) begin b_acc_q.push_back(cyc + 1); b_bits = 0; b_cap = '0; end
            if (b_prev && !b_sclk && !b_sync_n) begin b_cap = {b_cap[14:0], b_sdo}; b_bits++; end
            if (b_done) begin b_done_q.push_back(cyc + 1); b_word_q.push_back(int'(b_cap)); b_nbit_q.push_back(b_bits); end
            b_prev = b_sclk;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nacc(input bit sel);
        return sel ? b_acc_q.size() : a_acc_q.size();
    endfunction

    function automatic int ndone(input bit sel);
        return sel ? b_done_q.size() : a_done_q.size();
    endfunction

    task automatic wait_acc(input bit sel, input int n);
        int k = 0;
        while (nacc(sel) < n && k < 400) begin step(); k++; end
        if (nacc(sel) < n) chk("accept_timeout", nacc(sel), n);
    endtask

    task automatic wait_done(input bit sel, input int n);
        int k = 0;
        while (ndone(sel) < n && k < 400) begin step(); k++; end
        if (ndone(sel) < n) chk("done_timeout", ndone(sel), n);
    endtask

    task automatic wait_ready(input bit sel, output int stamp);
        int k = 0;
        while (!(sel ? b_if.s_ready : a_if.s_ready) && k < 400) begin step(); k++; end
        stamp = cyc + 1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_sync_n"}, int'(a_sync_n), 1);
        chk({tag, "_sclk"},   int'(a_sclk),   1);
        chk({tag, "_sdo"},    int'(a_sdo),    0);
        chk({tag, "_ready"},  int'(a_if.s_ready), 0);
        chk({tag, "_busy"},   int'(a_busy),   0);
        chk({tag, "_done"},   int'(a_done),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, st;
        rst_n = 1'b0; ena = 1'b0;
        a_if.s_valid = 1'b0; a_if.s_data = '0;
        b_if.s_valid = 1'b0; b_if.s_data = '0;
        repeat (3) step();
        chk_reset_a("rst");
        ena = 1'b1;
        #1 chk("rst_ready_ena1", int'(a_if.s_ready), 0);
        step(); rst_n = 1'b1;
        step();
        chk("post_rst_ready", int'(a_if.s_ready), 1);

        // single frame
        a_if.s_data = 16'hABCD; a_if.s_valid = 1'b1;
        wait_acc(0, 1); a_if.s_valid = 1'b0; t = a_acc_q[0];
        repeat (10) step();
        chk("mid_busy", int'(a_busy), 1);
        chk("mid_ready", int'(a_if.s_ready), 0);
        chk("mid_sync_n", int'(a_sync_n), 0);
        wait_done(0, 1);
        chk("f0_word", a_word_q[0], 'h0ABC);
        chk("f0_bits", a_nbit_q[0], 16);
        chk("f0_done_lat", a_done_q[0] - t, 65);
        wait_ready(0, st);
        chk("f0_ready_lat", st - t, 67);
        $display("txn single    word=%04h done_lat=%0d", a_word_q[0], a_done_q[0] - t);

        // back-to-back with s_valid held
        a_if.s_data = 16'hFFFF; a_if.s_valid = 1'b1;
        wait_acc(0, 2); a_if.s_data = 16'h0000;
        wait_acc(0, 3); a_if.s_valid = 1'b0;
        chk("b2b_period", a_acc_q[2] - a_acc_q[1], 67);
        wait_done(0, 3);
        chk("b2b_word1", a_word_q[1], 'h0FFF);
        chk("b2b_word2", a_word_q[2], 'h0000);
        $display("txn b2b       words=%04h,%04h period=%0d", a_word_q[1], a_word_q[2], a_acc_q[2] - a_acc_q[1]);

        // s_data changes while busy
        a_if.s_data = 16'h5555; a_if.s_valid = 1'b1;
        wait_acc(0, 4); t = a_acc_q[3];
        while (cyc < t + 9) step();
        a_if.s_data = 16'h1234;
        wait_acc(0, 5); a_if.s_valid = 1'b0;
        wait_done(0, 5);
        chk("busy_word_kept", a_word_q[3], 'h0555);
        chk("busy_word_next", a_word_q[4], 'h0123);
        chk("busy_period", a_acc_q[4] - t, 67);
        $display("txn busy_chg  words=%04h,%04h", a_word_q[3], a_word_q[4]);

        // ena drops mid-frame
        a_if.s_data = 16'h8765; a_if.s_valid = 1'b1;
        wait_acc(0, 6); t = a_acc_q[5]; a_if.s_data = 16'h4321;
        while (cyc < t + 19) step();
        ena = 1'b0;
        wait_done(0, 6);
        chk("ena_word", a_word_q[5], 'h0876);
        chk("ena_done_lat", a_done_q[5] - t, 65);
        repeat (10) step();
        chk("ena_ready_low", int'(a_if.s_ready), 0);
        chk("ena_no_accept", nacc(0), 6);
        chk("ena_idle_busy", int'(a_busy), 0);
        ena = 1'b1;
        wait_acc(0, 7);
        ena = 1'b0; a_if.s_valid = 1'b0;
        chk("ena_fall_busy", int'(a_busy), 1);
        wait_done(0, 7);
        chk("ena_fall_word", a_word_q[6], 'h0432);
        step();
        chk("ena0_ready", int'(a_if.s_ready), 0);
        ena = 1'b1;
        #1 chk("ena1_ready", int'(a_if.s_ready), 1);
        $display("txn ena_drop  words=%04h,%04h", a_word_q[5], a_word_q[6]);

        // reset in mid-frame
        a_if.s_data = 16'h0F0F; a_if.s_valid = 1'b1;
        wait_acc(0, 8); a_if.s_valid = 1'b0;
        repeat (20) step();
        chk("pre_rst_sync_n", int'(a_sync_n), 0);
        rst_n = 1'b0;
        #1 chk_reset_a("midrst");
        step(); step();
        rst_n = 1'b1;
        step();
        chk("midrst_ready", int'(a_if.s_ready), 1);
        repeat (80) step();
        chk("midrst_no_done", ndone(0), 7);
        $display("txn mid_reset aborted frames_done=%0d", ndone(0));

        // fast driver: CLK_DIV=1, GAP_CYCLES=1
        b_if.s_data = 16'hC3A5; b_if.s_valid = 1'b1;
        wait_acc(1, 1); b_if.s_valid = 1'b0; t = b_acc_q[0];
        wait_done(1, 1);
        chk("fast_word", b_word_q[0], 'h0C3A);
        chk("fast_bits", b_nbit_q[0], 16);
        chk("fast_done_lat", b_done_q[0] - t, 33);
        wait_ready(1, st);
        chk("fast_ready_lat", st - t, 34);
        $display("txn fast      word=%04h done_lat=%0d", b_word_q[0], b_done_q[0] - t);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
